adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of per-port operation counters (used only with ADDER_ARB_STATS_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0  input  1  port 0 request; held until gnt0.
REQ-005 a0, b0  input  3 each  port 0 operands; stable while req0 high.
REQ-006 gnt0  output  1  one-cycle grant to port 0; operands captured.
REQ-007 req1, a1, b1, gnt1: same as REQ-004..006 for port 1.
REQ-008 res  output  4  unsigned sum of the granted operands.
REQ-009 res_vld  output  1  one-cycle pulse, res valid.
REQ-010 res_id  output  1  port owning res (0/1).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 ops0, ops1  output  CNT_W each  grant counters (only with ADDER_ARB_STATS_EN).

Function
REQ-013 FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-014 IDLE: if req0 or req1 sampled high, latch winner's operands, record owner, go to CALC; else stay.
REQ-015 CALC: gnt of owner high this cycle only; register 4-bit sum into res; go to DONE.
REQ-016 DONE: res_vld=1, res_id=owner; update last-served to owner; go to IDLE.
REQ-017 Latency: req sampled at edge N -> gnt high in cycle N+1 -> res_vld high in cycle N+2; one operation per 3 cycles max.
REQ-018 Arbitration round-robin: single request wins; both requesting -> port not last served wins.
REQ-019 Last-served register resets to 1, so port 0 wins the first tie.
REQ-020 Requests arriving in CALC or DONE are ignored until next IDLE sample; no queueing.
REQ-021 Requester dropping req before grant withdraws cleanly; no gnt, no result.
REQ-022 Requester holding req after gnt is re-arbitrated as a new request in the following IDLE cycle.
REQ-023 Sum is zero-extended 3+3 -> 4 bits, no overflow possible; max 7+7 = 14.
REQ-024 res and res_id hold their value between res_vld pulses.
REQ-025 gnt0 and gnt1 never high in the same cycle; at most one of gnt/res_vld per port per operation.

Reset
REQ-026 rst_n low forces immediately: state IDLE, gnt0=gnt1=0, res=0, res_vld=0, res_id=0, busy=0, last-served=1, counters 0.
REQ-027 Reset in CALC or DONE aborts the operation; no res_vld issued after reset release.

Configuration
REQ-028 Macro ADDER_ARB_STATS_EN defined: ops0/ops1 present, increment on each gnt0/gnt1, saturate at 2^CNT_W-1.
REQ-029 Macro not defined: ops0/ops1 ports and counter logic absent; all other behaviour identical.

Structure
REQ-030 Shared package adder_arb_pkg holds state enumeration (IDLE, CALC, DONE), port-id constants PORT0=0/PORT1=1, operand width 3, result width 4.
REQ-031 One sub-module: existing adder3 instantiated for the sum, fed from latched operands; no other arithmetic in this block.

Verification
REQ-032 Reset, req0=1 a0=3 b0=4 -> gnt0 one cycle later, next cycle res_vld=1 res=7 res_id=0.
REQ-033 req0 and req1 high together from reset, held through grants -> grant order 0,1,0,1; results match each port's operands.
REQ-034 a1=7 b1=7 -> res=14 res_id=1; a0=0 b0=0 -> res=0.
REQ-035 req1 pulsed one cycle while busy (CALC) -> no gnt1, no extra res_vld.
REQ-036 rst_n low during CALC -> gnt/res_vld/busy 0 immediately; no res_vld after release until new req.
REQ-037 With ADDER_ARB_STATS_EN, CNT_W=2, five port-0 grants -> ops0 = 3 (saturated), ops1 = 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared types and constants for the two-port adder arbiter:
//               FSM state encoding, port identifiers and datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

   // Operand and result widths of the shared adder
   localparam int OP_W  = 3;
   localparam int RES_W = 4;

   // Port identifiers as carried in owner / last-served / res_id
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : adder_arb_pkg
`default_nettype wire

// File: rtl/adder3.sv
`default_nettype none
// ============================================================================
// Module      : adder3
// Description : Unsigned 3-bit + 3-bit adder, zero-extended to a 4-bit sum.
//               Purely combinational; 7 + 7 = 14 fits without overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module adder3
   import adder_arb_pkg::*;
(
   input  logic [OP_W-1:0]  a_i,
   input  logic [OP_W-1:0]  b_i,
   output logic [RES_W-1:0] sum_o
);

   // Zero-extend both operands before adding so the carry lands in the MSB
   always_comb begin
      sum_o = {1'b0, a_i} + {1'b0, b_i};
   end

endmodule : adder3
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter granting one of two requesters access to
//               a shared 3-bit adder. IDLE samples requests and latches the
//               winner's operands, CALC issues the one-cycle grant and
//               registers the sum, DONE pulses res_vld.
//               Optional build macro ADDER_ARB_STATS_EN adds the CNT_W
//               parameter and saturating per-port grant counters ops0/ops1.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
   import adder_arb_pkg::*;
`ifdef ADDER_ARB_STATS_EN
#(
   parameter int unsigned CNT_W = 8
)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [OP_W-1:0]  a0,
   input  logic [OP_W-1:0]  b0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [OP_W-1:0]  a1,
   input  logic [OP_W-1:0]  b1,
   output logic             gnt1,
   output logic [RES_W-1:0] res,
   output logic             res_vld,
   output logic             res_id,
   output logic             busy
`ifdef ADDER_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] ops0,
   output logic [CNT_W-1:0] ops1
`endif
);

   state_e           state_q,  state_d;
   logic             owner_q,  owner_d;
   logic             last_q,   last_d;
   logic [OP_W-1:0]  opa_q,    opa_d;
   logic [OP_W-1:0]  opb_q,    opb_d;
   logic [RES_W-1:0] res_q,    res_d;
   logic             res_id_q, res_id_d;
   logic [RES_W-1:0] sum_w;
   logic             winner_w;

   // The only arithmetic in this block: sum of the latched operands
   adder3 u_adder3 (
      .a_i   (opa_q),
      .b_i   (opb_q),
      .sum_o (sum_w)
   );

   // State and datapath registers; async reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= PORT0;
         last_q   <= PORT1;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         res_id_q <= PORT0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         res_id_q <= res_id_d;
      end
   end

   // Next-state logic: round-robin pick in IDLE, capture sum in CALC,
   // record the served port in DONE
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      res_id_d = res_id_q;
      winner_w = PORT0;

      // On a tie the port not served last wins; otherwise the lone requester
      if (req0 && req1) begin
         winner_w = (last_q == PORT0) ? PORT1 : PORT0;
      end else if (req1) begin
         winner_w = PORT1;
      end

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               owner_d = winner_w;
               opa_d   = (winner_w == PORT1) ? a1 : a0;
               opb_d   = (winner_w == PORT1) ? b1 : b0;
               state_d = CALC;
            end
         end
         CALC: begin
            res_d    = sum_w;
            res_id_d = owner_q;
            state_d  = DONE;
         end
         DONE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode straight from state so reset clears them immediately
   always_comb begin
      gnt0    = (state_q == CALC) && (owner_q == PORT0);
      gnt1    = (state_q == CALC) && (owner_q == PORT1);
      res_vld = (state_q == DONE);
      busy    = (state_q != IDLE);
      res     = res_q;
      res_id  = res_id_q;
   end

`ifdef ADDER_ARB_STATS_EN
   logic [CNT_W-1:0] ops0_q, ops0_d;
   logic [CNT_W-1:0] ops1_q, ops1_d;

   // Grant counters stick at all-ones rather than wrapping
   always_comb begin
      ops0_d = ops0_q;
      ops1_d = ops1_q;
      if (gnt0 && (ops0_q != {CNT_W{1'b1}})) begin
         ops0_d = ops0_q + 1'b1;
      end
      if (gnt1 && (ops1_q != {CNT_W{1'b1}})) begin
         ops1_d = ops1_q + 1'b1;
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops0_q <= '0;
         ops1_q <= '0;
      end else begin
         ops0_q <= ops0_d;
         ops1_q <= ops1_d;
      end
   end

   assign ops0 = ops0_q;
   assign ops1 = ops1_q;
`endif

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed self-checking bench for adder_arbiter. Build with
//               ADDER_ARB_STATS_EN to also exercise the grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [2:0] a0, b0, a1, b1;
   logic       gnt0, gnt1;
   logic [3:0] res;
   logic       res_vld, res_id, busy;
`ifdef ADDER_ARB_STATS_EN
   logic [1:0] ops0, ops1;
`endif

   int pass_cnt;
   int fail_cnt;
   int total_cnt;

`ifdef ADDER_ARB_STATS_EN
   adder_arbiter #(.CNT_W(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .a0      (a0),
      .b0      (b0),
      .gnt0    (gnt0),
      .req1    (req1),
      .a1      (a1),
      .b1      (b1),
      .gnt1    (gnt1),
      .res     (res),
      .res_vld (res_vld),
      .res_id  (res_id),
      .busy    (busy),
      .ops0    (ops0),
      .ops1    (ops1)
   );
`else
   adder_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (req0),
      .a0      (a0),
      .b0      (b0),
      .gnt0    (gnt0),
      .req1    (req1),
      .a1      (a1),
      .b1      (b1),
      .gnt1    (gnt1),
      .res     (res),
      .res_vld (res_vld),
      .res_id  (res_id),
      .busy    (busy)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
      end
   endtask

   initial begin
      pass_cnt  = 0;
      fail_cnt  = 0;
      total_cnt = 0;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;

      // ---- reset state ----
      #1;
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_res", res, 0);
      check("rst_res_vld", res_vld, 0);
      check("rst_res_id", res_id, 0);
      check("rst_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;

      // ---- single op: 3 + 4 on port 0 ----
      req0 = 1'b1; a0 = 3'd3; b0 = 3'd4;
      step();
      check("op1_gnt0", gnt0, 1);
      check("op1_gnt1", gnt1, 0);
      check("op1_busy", busy, 1);
      check("op1_vld_early", res_vld, 0);
      req0 = 1'b0;
      step();
      check("op1_res_vld", res_vld, 1);
      check("op1_res", res, 7);
      check("op1_res_id", res_id, 0);
      check("op1_gnt0_off", gnt0, 0);
      step();
      check("op1_idle_vld", res_vld, 0);
      check("op1_idle_busy", busy, 0);
      check("op1_res_hold", res, 7);

      // ---- fresh reset, both ports held: grants alternate 0,1,0,1 ----
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req0 = 1'b1; a0 = 3'd0; b0 = 3'd0;
      req1 = 1'b1; a1 = 3'd7; b1 = 3'd7;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rr%0d_gnt0", k), gnt0, (k % 2 == 0) ? 1 : 0);
         check($sformatf("rr%0d_gnt1", k), gnt1, (k % 2 == 1) ? 1 : 0);
         step();
         check($sformatf("rr%0d_vld", k), res_vld, 1);
         check($sformatf("rr%0d_res", k), res, (k % 2 == 0) ? 0 : 14);
         check($sformatf("rr%0d_id", k), res_id, k % 2);
         if (k == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         step();
         check($sformatf("rr%0d_idle_gnt", k), gnt0 | gnt1, 0);
         check($sformatf("rr%0d_hold_id", k), res_id, k % 2);
      end

      // ---- req1 pulsed during CALC is ignored ----
      req0 = 1'b1; a0 = 3'd2; b0 = 3'd5;
      step();
      check("ign_gnt0", gnt0, 1);
      req0 = 1'b0;
      req1 = 1'b1; a1 = 3'd6; b1 = 3'd1;
      step();
      req1 = 1'b0;
      check("ign_vld", res_vld, 1);
      check("ign_res", res, 7);
      check("ign_id", res_id, 0);
      check("ign_gnt1_done", gnt1, 0);
      step();
      check("ign_gnt1_idle", gnt1, 0);
      check("ign_busy_idle", busy, 0);
      step();
      check("ign_no_extra_vld", res_vld, 0);
      check("ign_no_extra_busy", busy, 0);

      // ---- reset during CALC aborts the operation ----
      req1 = 1'b1; a1 = 3'd5; b1 = 3'd1;
      step();
      check("abort_gnt1", gnt1, 1);
      req1 = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_gnt1_off", gnt1, 0);
      check("abort_vld", res_vld, 0);
      check("abort_busy", busy, 0);
      check("abort_res", res, 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("post_rst_vld%0d", k), res_vld, 0);
         check($sformatf("post_rst_busy%0d", k), busy, 0);
      end

      // ---- tie right after reset goes to port 0 ----
      req0 = 1'b1; a0 = 3'd1; b0 = 3'd1;
      req1 = 1'b1; a1 = 3'd4; b1 = 3'd4;
      step();
      check("tie_gnt0", gnt0, 1);
      check("tie_gnt1", gnt1, 0);
      req0 = 1'b0;
      step();
      check("tie_res", res, 2);
      step();
      step();
      check("tie2_gnt1", gnt1, 1);
      req1 = 1'b0;
      step();
      check("tie2_res", res, 8);
      check("tie2_id", res_id, 1);
      step();

`ifdef ADDER_ARB_STATS_EN
      // ---- counters saturate at 3 with CNT_W = 2 ----
      rst_n = 1'b0;
      step();
      check("stat_rst_ops0", ops0, 0);
      rst_n = 1'b1;
      req0 = 1'b1; a0 = 3'd1; b0 = 3'd2;
      for (int k = 0; k < 15; k++) begin
         step();
      end
      req0 = 1'b0;
      step();
      check("stat_ops0_sat", ops0, 3);
      check("stat_ops1", ops1, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_adder_arbiter
`default_nettype wire
